// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared types and constants for the 2x2 camera exposure
//               controller. Provides the sequencer state enum, readout
//               timing constants and the exposure-time register width.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPOSE = 3'd1,
    S_READ1  = 3'd2,
    S_GAP    = 3'd3,
    S_READ2  = 3'd4
  } state_e;

  // Each row read lasts READ_CYCLES cycles; the ADC strobe fires on the
  // ADC_POS-th cycle (1-based) of each row read.
  localparam int READ_CYCLES = 3;
  localparam int ADC_POS     = 2;

  // Exposure time register width (ms)
  localparam int EXP_W = 5;

  // Row-read cycle counter is 0-based; these are its decode points.
  localparam logic [1:0] RD_LAST = 2'(READ_CYCLES - 1);
  localparam logic [1:0] RD_ADC  = 2'(ADC_POS - 1);

endpackage
`default_nettype wire

// File: rtl/cam_exp_timer.sv
`default_nettype none
// ============================================================================
// Module      : cam_exp_timer
// Description : Loadable down-counter that times the exposure window.
//               done is high for one cycle while the count sits at its
//               terminal value (1), so the edge that ends the window is
//               exactly 'value' edges after the load edge.
// Ports       : Clk   - system clock, rising edge
//               Reset - synchronous, active-low reset (clears the count)
//               load  - load 'value' into the counter
//               value - number of cycles to time
//               done  - terminal-count pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cam_exp_timer #(
  parameter int WIDTH = 15
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A load in the same cycle overrides a pending terminal count.
  assign done = !load && (count_q == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/camera_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : camera_ctrl_seq
// Description : Exposure controller for the 2x2 pixel-array camera. Holds
//               the programmable exposure time (ms) and sequences the pixel
//               array through erase, exposure and a two-row readout with an
//               ADC strobe per row. All outputs are registered.
// Ports       : Clk, Reset (sync, active-low)
//               Init, Exp_increase, Exp_decrease, Take_Pic - one-cycle pulses
//               Erase, Expose, NRE_1, NRE_2 (active low), ADC, Busy
//               Exp_time - current exposure time in ms
// Build option: CAM_ABORT_EN - when defined, Init during EXPOSE aborts the
//               capture and returns to IDLE without readout.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_ctrl_seq
  import cam_pkg::*;
#(
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 15,
  parameter int TICKS_PER_MS = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Take_Pic,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output logic [EXP_W-1:0] Exp_time
);

  localparam int TIMER_W = $clog2(EXP_MAX * TICKS_PER_MS + 1);

  localparam logic [EXP_W-1:0] EXP_MIN_V = EXP_W'(EXP_MIN);
  localparam logic [EXP_W-1:0] EXP_MAX_V = EXP_W'(EXP_MAX);
  localparam logic [EXP_W-1:0] EXP_DEF_V = EXP_W'(EXP_DEFAULT);

  state_e             state_q,    state_d;
  logic [EXP_W-1:0]   exp_time_q, exp_time_d;
  logic [1:0]         rd_cnt_q,   rd_cnt_d;
  logic               erase_q,    erase_d;
  logic               expose_q,   expose_d;
  logic               nre_1_q,    nre_1_d;
  logic               nre_2_q,    nre_2_d;
  logic               adc_q,      adc_d;
  logic               busy_q,     busy_d;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic               tmr_done;

  cam_exp_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Next state, exposure register and timer control
  always_comb begin
    state_d    = state_q;
    exp_time_d = exp_time_q;
    rd_cnt_d   = rd_cnt_q;
    tmr_load   = 1'b0;
    tmr_value  = '0;

    case (state_q)
      S_IDLE: begin
        if (Init) begin
          exp_time_d = EXP_DEF_V;
        end else if (Take_Pic) begin
          state_d   = S_EXPOSE;
          tmr_load  = 1'b1;
          tmr_value = TIMER_W'(exp_time_q) * TIMER_W'(TICKS_PER_MS);
        end else if (Exp_increase && !Exp_decrease) begin
          if (exp_time_q < EXP_MAX_V) exp_time_d = exp_time_q + EXP_W'(1);
        end else if (Exp_decrease && !Exp_increase) begin
          if (exp_time_q > EXP_MIN_V) exp_time_d = exp_time_q - EXP_W'(1);
        end
      end

      S_EXPOSE: begin
`ifdef CAM_ABORT_EN
        if (Init) begin
          // Abort: also flush the timer so no stale done pulse remains.
          state_d   = S_IDLE;
          tmr_load  = 1'b1;
          tmr_value = '0;
        end else if (tmr_done) begin
          state_d  = S_READ1;
          rd_cnt_d = '0;
        end
`else
        if (tmr_done) begin
          state_d  = S_READ1;
          rd_cnt_d = '0;
        end
`endif
      end

      S_READ1: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d  = S_GAP;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end

      S_GAP: begin
        state_d  = S_READ2;
        rd_cnt_d = '0;
      end

      S_READ2: begin
        if (rd_cnt_q == RD_LAST) begin
          state_d  = S_IDLE;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d  = S_IDLE;
        rd_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they can be registered
  // alongside it and still line up with the state they describe.
  always_comb begin
    erase_d  = (state_d == S_IDLE);
    expose_d = (state_d == S_EXPOSE);
    nre_1_d  = (state_d != S_READ1);
    nre_2_d  = (state_d != S_READ2);
    adc_d    = ((state_d == S_READ1) || (state_d == S_READ2)) && (rd_cnt_d == RD_ADC);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      exp_time_q <= EXP_DEF_V;
      rd_cnt_q   <= '0;
      erase_q    <= 1'b1;
      expose_q   <= 1'b0;
      nre_1_q    <= 1'b1;
      nre_2_q    <= 1'b1;
      adc_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_time_q <= exp_time_d;
      rd_cnt_q   <= rd_cnt_d;
      erase_q    <= erase_d;
      expose_q   <= expose_d;
      nre_1_q    <= nre_1_d;
      nre_2_q    <= nre_2_d;
      adc_q      <= adc_d;
      busy_q     <= busy_d;
    end
  end

  assign Erase    = erase_q;
  assign Expose   = expose_q;
  assign NRE_1    = nre_1_q;
  assign NRE_2    = nre_2_q;
  assign ADC      = adc_q;
  assign Busy     = busy_q;
  assign Exp_time = exp_time_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_ctrl_seq
// Description : Self-checking bench for camera_ctrl_seq (TICKS_PER_MS = 4).
//               The driver pushes the expected output vector
//               {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Exp_time} for each cycle
//               it drives; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_ctrl_seq;

  logic       Clk;
  logic       Reset;
  logic       Init;
  logic       Exp_increase;
  logic       Exp_decrease;
  logic       Take_Pic;
  logic       Erase;
  logic       Expose;
  logic       NRE_1;
  logic       NRE_2;
  logic       ADC;
  logic       Busy;
  logic [4:0] Exp_time;

  typedef struct {
    logic [10:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   inv_on = 1'b0;

  camera_ctrl_seq #(
    .EXP_MIN      (2),
    .EXP_MAX      (30),
    .EXP_DEFAULT  (15),
    .TICKS_PER_MS (4)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Init         (Init),
    .Exp_increase (Exp_increase),
    .Exp_decrease (Exp_decrease),
    .Take_Pic     (Take_Pic),
    .Erase        (Erase),
    .Expose       (Expose),
    .NRE_1        (NRE_1),
    .NRE_2        (NRE_2),
    .ADC          (ADC),
    .Busy         (Busy),
    .Exp_time     (Exp_time)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Expected vectors: {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Exp_time}
  function automatic logic [10:0] v_idle(input logic [4:0] et);
    return {6'b101100, et};
  endfunction
  function automatic logic [10:0] v_exp(input logic [4:0] et);
    return {6'b011101, et};
  endfunction
  function automatic logic [10:0] v_r1(input logic adc, input logic [4:0] et);
    return {4'b0001, adc, 1'b1, et};
  endfunction
  function automatic logic [10:0] v_gap(input logic [4:0] et);
    return {6'b001101, et};
  endfunction
  function automatic logic [10:0] v_r2(input logic adc, input logic [4:0] et);
    return {4'b0010, adc, 1'b1, et};
  endfunction

  // Monitor: compares whatever the driver queued for this cycle, plus the
  // pixel-safety invariants once reset has been applied.
  always @(negedge Clk) begin
    logic [10:0] act;
    exp_t        e;
    act = {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Exp_time};
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b (t=%0t)", e.nm, act, e.v, $time);
      end
    end
    if (inv_on) begin
      checks++;
      if ((!NRE_1 && !NRE_2) || (Expose && Erase)) begin
        errors++;
        $display("FAIL invariant: NRE_1=%b NRE_2=%b Expose=%b Erase=%b required no overlap (t=%0t)",
                 NRE_1, NRE_2, Expose, Erase, $time);
      end
    end
  end

  // Apply pulse inputs for one edge, then queue the outputs expected after it.
  task automatic tick(input bit ini, input bit tp, input bit inc, input bit dec,
                      input logic [10:0] e, input string nm);
    exp_t x;
    Init         = ini;
    Take_Pic     = tp;
    Exp_increase = inc;
    Exp_decrease = dec;
    @(posedge Clk);
    #1;
    Init         = 1'b0;
    Take_Pic     = 1'b0;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    x.v  = e;
    x.nm = nm;
    q.push_back(x);
  endtask

  // Full capture at exposure 'et'; with noise, Take_Pic/inc/dec are pulsed
  // throughout the exposure and must have no effect.
  task automatic capture(input logic [4:0] et, input bit noise, input string nm);
    int n;
    n = int'(et) * 4;
    tick(1'b0, 1'b1, noise, 1'b0, v_exp(et), {nm, "_start"});
    for (int i = 1; i < n; i++) begin
      tick(1'b0, noise && (i % 3 == 0), noise && (i % 3 == 1), noise && (i % 3 == 2),
           v_exp(et), {nm, "_expose"});
    end
    tick(0, 0, 0, 0, v_r1(1'b0, et), {nm, "_r1a"});
    tick(0, 0, 0, 0, v_r1(1'b1, et), {nm, "_r1adc"});
    tick(0, 0, 0, 0, v_r1(1'b0, et), {nm, "_r1c"});
    tick(0, 0, 0, 0, v_gap(et),      {nm, "_gap"});
    tick(0, 0, 0, 0, v_r2(1'b0, et), {nm, "_r2a"});
    tick(0, 0, 0, 0, v_r2(1'b1, et), {nm, "_r2adc"});
    tick(0, 0, 0, 0, v_r2(1'b0, et), {nm, "_r2c"});
    tick(0, 0, 0, 0, v_idle(et),     {nm, "_done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] et;
    Reset        = 1'b0;
    Init         = 1'b0;
    Take_Pic     = 1'b0;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;

    // Reset held for two edges
    tick(0, 0, 0, 0, v_idle(5'd15), "reset0");
    tick(0, 0, 0, 0, v_idle(5'd15), "reset1");
    Reset  = 1'b1;
    inv_on = 1'b1;
    tick(0, 0, 0, 0, v_idle(5'd15), "idle_after_reset");

    // Default exposure: 60 expose cycles then readout; second capture is
    // started on the first IDLE cycle and carries ignored-input noise.
    capture(5'd15, 1'b0, "cap15");
    capture(5'd15, 1'b1, "cap15_noise");

    // Init has priority over Take_Pic
    tick(1, 1, 0, 0, v_idle(5'd15), "init_over_take");

    // Increase to saturation, then decrease to saturation
    for (int i = 1; i <= 20; i++) begin
      et = (15 + i > 30) ? 5'd30 : 5'(15 + i);
      tick(0, 0, 1, 0, v_idle(et), "inc");
    end
    for (int i = 1; i <= 40; i++) begin
      et = (30 - i < 2) ? 5'd2 : 5'(30 - i);
      tick(0, 0, 0, 1, v_idle(et), "dec");
    end
    tick(0, 0, 1, 1, v_idle(5'd2), "incdec_at_min");
    tick(0, 0, 1, 0, v_idle(5'd3), "inc_from_min");
    tick(0, 0, 1, 1, v_idle(5'd3), "incdec_mid");
    tick(0, 0, 0, 1, v_idle(5'd2), "dec_to_min");

    // Shortest exposure
    capture(5'd2, 1'b0, "cap2");

    // Init during EXPOSE
    tick(0, 1, 0, 0, v_exp(5'd2), "abort_start");
    tick(0, 0, 0, 0, v_exp(5'd2), "abort_expose");
    tick(0, 0, 0, 0, v_exp(5'd2), "abort_expose");
`ifdef CAM_ABORT_EN
    tick(1, 0, 0, 0, v_idle(5'd2), "abort_idle");
    for (int i = 0; i < 10; i++) tick(0, 0, 0, 0, v_idle(5'd2), "abort_no_readout");
`else
    tick(1, 0, 0, 0, v_exp(5'd2), "init_ignored");
    for (int i = 4; i < 8; i++) tick(0, 0, 0, 0, v_exp(5'd2), "init_ignored_expose");
    tick(0, 0, 0, 0, v_r1(1'b0, 5'd2), "init_ignored_r1a");
    tick(0, 0, 0, 0, v_r1(1'b1, 5'd2), "init_ignored_r1adc");
    tick(0, 0, 0, 0, v_r1(1'b0, 5'd2), "init_ignored_r1c");
    tick(0, 0, 0, 0, v_gap(5'd2),      "init_ignored_gap");
    tick(0, 0, 0, 0, v_r2(1'b0, 5'd2), "init_ignored_r2a");
    tick(0, 0, 0, 0, v_r2(1'b1, 5'd2), "init_ignored_r2adc");
    tick(0, 0, 0, 0, v_r2(1'b0, 5'd2), "init_ignored_r2c");
    tick(0, 0, 0, 0, v_idle(5'd2),     "init_ignored_done");
`endif

    // Init restores default; bump to 16 so reset's restore is visible
    tick(1, 0, 0, 0, v_idle(5'd15), "init_default");
    tick(0, 0, 1, 0, v_idle(5'd16), "inc_to_16");

    // Reset in the 10th EXPOSE cycle aborts with no readout
    tick(0, 1, 0, 0, v_exp(5'd16), "rst_cap_start");
    for (int i = 2; i <= 10; i++) tick(0, 0, 0, 0, v_exp(5'd16), "rst_cap_expose");
    Reset = 1'b0;
    tick(0, 0, 0, 0, v_idle(5'd15), "rst_mid_capture");
    Reset = 1'b1;
    for (int i = 0; i < 12; i++) tick(0, 0, 0, 0, v_idle(5'd15), "rst_no_readout");

    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
